fetch_line_writer: RTL and testbench

Producer side of the instruction fetch queue. It fetches 4-word instruction lines from instruction memory over a request/grant, in-order-beat interface and pushes each returned word into the fetch queue. On a branch redirect it flushes the queue, sets the queue read offset to the target word within the line, and restarts fetching at the target's line-aligned address. Beats still outstanding from the old path are discarded.

---
 rtl/fetch_line_writer_if.sv | 31 +++
 rtl/fetch_line_writer.sv | 120 ++++++++++++
 tb/tb_fetch_line_writer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_line_writer_if.sv
// Bundle of the instruction-memory port and the fetch-queue write port of the fetch line writer.
// Handshakes: mem_req/mem_addr stay stable until the cycle mem_gnt is high (mem_req && mem_gnt = accepted);
// mem_rvalid qualifies mem_rdata for one cycle and q_push qualifies q_data for one cycle, with no back-pressure on either.
interface fetch_line_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PTR_WIDTH  = 7
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  q_push;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  q_full;
  logic [PTR_WIDTH-1:0]  q_wp;
  logic [PTR_WIDTH-1:0]  q_rp;
  logic                  q_flush;
  logic [1:0]            q_offset;

  modport master (
    output mem_req, mem_addr, q_push, q_data, q_flush, q_offset,
    input  mem_gnt, mem_rvalid, mem_rdata, q_full, q_wp, q_rp
  );

  modport slave (
    input  mem_req, mem_addr, q_push, q_data, q_flush, q_offset,
    output mem_gnt, mem_rvalid, mem_rdata, q_full, q_wp, q_rp
  );
endinterface

// File: rtl/fetch_line_writer.sv
// Fetch-queue producer: requests 4-word lines from instruction memory and pushes the returned words,
// flushing and restarting at the target line on a redirect while discarding beats of the old path.
module fetch_line_writer #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    Depth_Of_FIFO = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_line_writer_if.master   bus,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);
  localparam int PTR_WIDTH = $clog2(Depth_Of_FIFO) + 1;
  localparam logic [PTR_WIDTH-1:0] SPACE_LIMIT = PTR_WIDTH'(Depth_Of_FIFO - 4);

  typedef enum logic [2:0] {
    WAIT_SPACE  = 3'd0,
    REQ         = 3'd1,
    BURST       = 3'd2,
    REQ_DISCARD = 3'd3,
    DRAIN       = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] line_next;
  logic [ADDR_WIDTH-1:0] redirect_line;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req;
  logic                  first_line;
  logic [1:0]            beat_cnt;
  logic [PTR_WIDTH-1:0]  occupancy;
  logic                  space_ok;
  logic                  last_beat;
  logic                  hold_addr;
  logic                  unused_pc_bits;

  assign redirect_line  = {redirect_pc[ADDR_WIDTH-1:4], 4'b0000};
  assign occupancy      = bus.q_wp - bus.q_rp;
  // The first line after reset/redirect skips the check: pointers are transiently wp=0, rp=offset.
  assign space_ok       = first_line || (occupancy <= SPACE_LIMIT);
  assign last_beat      = bus.mem_rvalid && (beat_cnt == 2'd3);
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    line_next = line_addr;
    if (state == BURST && last_beat) line_next = line_addr + ADDR_WIDTH'(16);
    if (redirect) line_next = redirect_line;
  end

  // An un-granted request keeps its address even when a redirect moves line_addr.
  assign hold_addr = (state == REQ || state == REQ_DISCARD) && !bus.mem_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_SPACE;
      line_addr  <= RESET_PC;
      req_addr   <= RESET_PC;
      req        <= 1'b0;
      first_line <= 1'b1;
      beat_cnt   <= 2'd0;
      overflow   <= 1'b0;
    end else begin
      line_addr <= line_next;
      if (!hold_addr) req_addr <= line_next;
      if (bus.q_push && bus.q_full) overflow <= 1'b1;

      case (state)
        WAIT_SPACE: begin
          if (!redirect && space_ok) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            req        <= 1'b0;
            beat_cnt   <= 2'd0;
            first_line <= 1'b0;
            state      <= redirect ? DRAIN : BURST;
          end else if (redirect) begin
            state <= REQ_DISCARD;
          end
        end
        BURST: begin
          if (bus.mem_rvalid) beat_cnt <= beat_cnt + 2'd1;
          // A redirect on the final beat has nothing left to drain.
          if (last_beat) state <= WAIT_SPACE;
          else if (redirect) state <= DRAIN;
        end
        REQ_DISCARD: begin
          if (bus.mem_gnt) begin
            req      <= 1'b0;
            beat_cnt <= 2'd0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) beat_cnt <= beat_cnt + 2'd1;
          if (last_beat) state <= WAIT_SPACE;
        end
        default: state <= WAIT_SPACE;
      endcase

      if (redirect) first_line <= 1'b1;
    end
  end

  assign bus.mem_req  = req;
  assign bus.mem_addr = req_addr;
  assign bus.q_push   = (state == BURST) && bus.mem_rvalid && !redirect;
  assign bus.q_data   = bus.mem_rdata;
  assign bus.q_flush  = redirect;
  assign bus.q_offset = redirect_pc[3:2];
  assign dbg_state    = state;
endmodule

// File: tb/tb_fetch_line_writer.sv
// Bench for fetch_line_writer: a randomised memory/queue model drives the DUT and a scoreboard
// predicts the pushed word stream from the redirect targets and sequential line order.
module tb_fetch_line_writer;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 8;
  localparam int          PW    = 4;
  localparam logic [31:0] RPC   = 32'h100;

  // ---------------- clock / reset ----------------
  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        overflow;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_line_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PTR_WIDTH(PW)) bus ();

  fetch_line_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Depth_Of_FIFO(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus(bus), .overflow(overflow), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory / queue model and scoreboard ----------------
  int unsigned gnt_pct    = 100;
  int unsigned rv_pct     = 100;
  bit          pop_en     = 1'b0;
  bit          force_full = 1'b0;
  int          beats      = 0;
  int          beat_idx   = 0;
  int          push_cnt   = 0;
  int          gnt_cnt    = 0;
  logic [31:0] cur_line   = '0;
  logic [31:0] last_gnt_addr = '0;
  logic [31:0] exp_line   = RPC;
  logic [3:0]  wp         = '0;
  logic [3:0]  rp         = '0;
  logic [3:0]  occ;
  logic [DW-1:0] exp_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.q_full = 1'b0; bus.q_wp = '0; bus.q_rp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        beats = 0; wp = '0; rp = '0; push_cnt = 0;
        bus.q_wp = '0; bus.q_rp = '0; bus.q_full = force_full;
        exp_q.delete(); exp_line = RPC;
        continue;
      end
      occ = wp - rp;
      if (pop_en && occ != 4'd0 && occ <= 4'd8 && $urandom_range(0, 1) == 1) rp = rp + 4'd1;
      occ = wp - rp;
      bus.q_wp = wp; bus.q_rp = rp;
      bus.q_full = force_full || (occ == 4'd8);
      bus.mem_rvalid = (beats > 0) && ($urandom_range(0, 99) < rv_pct);
      bus.mem_rdata  = bus.mem_rvalid ? word_at(cur_line + 32'(beat_idx * 4)) : $urandom;
      bus.mem_gnt    = bus.mem_req && (beats == 0) && ($urandom_range(0, 99) < gnt_pct);
      #1;
      if (bus.mem_req) chk("one_outstanding", 64'(beats), 64'(0));
      if (redirect) begin
        chk("flush_on_redirect", 64'(bus.q_flush), 64'(1));
        chk("offset_on_redirect", 64'(bus.q_offset), 64'(redirect_pc[3:2]));
        chk("no_push_in_redirect", 64'(bus.q_push), 64'(0));
        exp_q.delete();
        exp_line = {redirect_pc[31:4], 4'b0000};
        wp = '0;
        rp = 4'(redirect_pc[3:2]);
      end else begin
        chk("flush_idle", 64'(bus.q_flush), 64'(0));
      end
      if (bus.q_push) begin
        if (exp_q.size() == 0) begin
          for (int k = 0; k < 4; k++) exp_q.push_back(word_at(exp_line + 32'(k * 4)));
          exp_line = exp_line + 32'h10;
        end
        chk("push_data", 64'(bus.q_data), 64'(exp_q.pop_front()));
        push_cnt++;
        wp = wp + 4'd1;
      end
      if (bus.mem_gnt && bus.mem_req) begin
        chk("gnt_addr_align", 64'(bus.mem_addr[3:0]), 64'(0));
        cur_line = bus.mem_addr; last_gnt_addr = bus.mem_addr;
        beats = 4; beat_idx = 0; gnt_cnt++;
      end else if (bus.mem_rvalid) begin
        beat_idx++; beats--;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0;
    #2;
    chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(RPC));
    chk("rst_q_push", 64'(bus.q_push), 64'(0));
    chk("rst_q_flush", 64'(bus.q_flush), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic wait_gnt(input logic [31:0] exp_addr, input string tag, input int budget);
    int start = gnt_cnt;
    int n = 0;
    while (gnt_cnt == start && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_seen"}, 64'(gnt_cnt != start), 64'(1));
    chk(tag, 64'(last_gnt_addr), 64'(exp_addr));
  endtask

  task automatic wait_push(input int target, input string tag, input int budget);
    int n = 0;
    while (push_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk(tag, 64'(push_cnt >= target), 64'(1));
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int base;
    int p0;
    int n;
    logic [31:0] stall_addr;

    do_reset();

    // two lines fill a depth-8 queue, then no further request
    base = gnt_cnt;
    wait_gnt(32'h100, "req_0x100", 20);
    wait_gnt(32'h110, "req_0x110", 20);
    wait_push(8, "two_lines_pushed", 20);
    tick(40);
    chk("no_third_gnt", 64'(gnt_cnt - base), 64'(2));
    chk("no_third_req", 64'(bus.mem_req), 64'(0));
    chk("fill_push_total", 64'(push_cnt), 64'(8));
    chk("fill_overflow", 64'(overflow), 64'(0));
    rp = 4'd3;
    tick(10);
    chk("occ5_no_req", 64'(bus.mem_req), 64'(0));
    rp = 4'd4;
    wait_gnt(32'h120, "req_at_occ4", 20);
    wait_push(12, "third_line_pushed", 20);
    tick(10);

    // redirect in WAIT_SPACE (queue at occupancy 8)
    do_redirect(32'h208);
    wait_gnt(32'h200, "redir_ws_req", 10);
    wait_push(16, "redir_ws_line", 20);
    wait_gnt(32'h210, "redir_ws_next_line", 20);
    wait_push(20, "redir_ws_line2", 20);

    // redirect after two beats of a burst
    pop_en = 1'b1;
    wait_gnt(32'h220, "req_0x220", 100);
    n = 0;
    while (beat_idx < 2 && n < 50) begin @(negedge clk); n++; end
    chk("two_beats_before_redirect", 64'(beat_idx), 64'(2));
    p0 = push_cnt;
    do_redirect(32'h30C);
    wait_gnt(32'h300, "burst_redir_req", 40);
    chk("burst_redir_no_stale", 64'(push_cnt), 64'(p0));
    wait_push(p0 + 4, "burst_redir_new_line", 40);

    // redirect while the request is stalled
    gnt_pct = 0;
    n = 0;
    while (!bus.mem_req && n < 200) begin @(negedge clk); n++; end
    stall_addr = exp_line;
    tick(2);
    p0 = push_cnt;
    do_redirect(32'h604);
    tick(5);
    chk("stall_addr_hold", 64'(bus.mem_addr), 64'(stall_addr));
    chk("stall_req_hold", 64'(bus.mem_req), 64'(1));
    gnt_pct = 100;
    wait_gnt(stall_addr, "stale_gnt", 10);
    wait_gnt(32'h600, "req_after_stale", 40);
    chk("stall_no_stale_push", 64'(push_cnt), 64'(p0));
    wait_push(p0 + 4, "stall_new_line", 40);

    // back-to-back redirects during DRAIN
    rv_pct = 0;
    wait_gnt(exp_line, "req_before_drain", 200);
    p0 = push_cnt;
    do_redirect(32'h400);
    tick(2);
    do_redirect(32'h520);
    tick(3);
    rv_pct = 100;
    wait_gnt(32'h520, "final_addr_0x520", 60);
    chk("drain_no_stale_push", 64'(push_cnt), 64'(p0));
    wait_push(p0 + 4, "drain_new_line", 40);

    // randomised traffic with random redirects
    base = push_cnt;
    for (int i = 0; i < 60; i++) begin
      gnt_pct = $urandom_range(30, 100);
      rv_pct  = $urandom_range(30, 100);
      tick($urandom_range(5, 40));
      if ($urandom_range(0, 2) == 0) do_redirect($urandom_range(0, 32'hF000));
    end
    gnt_pct = 100; rv_pct = 100;
    tick(200);
    chk("random_progress", 64'(push_cnt > base), 64'(1));
    chk("random_overflow", 64'(overflow), 64'(0));

    // a push while the queue reports full sets the sticky flag
    pop_en = 1'b0;
    do_redirect(32'h700);
    force_full = 1'b1;
    p0 = push_cnt;
    n = 0;
    while (push_cnt == p0 && n < 60) begin @(negedge clk); n++; end
    force_full = 1'b0;
    tick(1);
    chk("overflow_set", 64'(overflow), 64'(1));
    tick(20);
    chk("overflow_sticky", 64'(overflow), 64'(1));
    do_reset();
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
